// File: rtl/fft_seq_pkg.sv
// rtl/fft_seq_pkg.sv - shared state encoding and {re, im} helpers for the FFT sequencer
package fft_seq_pkg;

    localparam int FFT_WIDTH = 16;
    localparam int FFT_M     = 5;

    // Largest positive value of a signed FFT_WIDTH component, held at sum width.
    localparam logic [FFT_WIDTH+1:0] MAG_MAX = {3'b000, {(FFT_WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        DRAIN
    } seq_state_t;

    function automatic logic [2*FFT_WIDTH-1:0] pack_cplx(
        input logic [FFT_WIDTH-1:0] re,
        input logic [FFT_WIDTH-1:0] im
    );
        return {re, im};
    endfunction

    // |re| + |im| clipped to the positive signed range; one extra bit covers |-2**(W-1)|.
    function automatic logic [FFT_WIDTH-1:0] mag_sat(input logic [2*FFT_WIDTH-1:0] d);
        logic [FFT_WIDTH-1:0] re;
        logic [FFT_WIDTH-1:0] im;
        logic [FFT_WIDTH:0]   are;
        logic [FFT_WIDTH:0]   aim;
        logic [FFT_WIDTH+1:0] sum;
        re  = d[2*FFT_WIDTH-1:FFT_WIDTH];
        im  = d[FFT_WIDTH-1:0];
        are = re[FFT_WIDTH-1] ? ({1'b0, ~re} + (FFT_WIDTH+1)'(1)) : {1'b0, re};
        aim = im[FFT_WIDTH-1] ? ({1'b0, ~im} + (FFT_WIDTH+1)'(1)) : {1'b0, im};
        sum = {1'b0, are} + {1'b0, aim};
        return (sum > MAG_MAX) ? MAG_MAX[FFT_WIDTH-1:0] : sum[FFT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fft_seq_buf.sv
// rtl/fft_seq_buf.sv - result buffer, one write port and one registered read port
module fft_seq_buf #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_adr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_adr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    // The read register doubles as the output holding register, so it only moves on rd_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - FFT frame sequencer; FFT_SEQ_MAG_EN selects |re|+|im| output
module fft_sequencer
    import fft_seq_pkg::*;
#(
    parameter int WIDTH   = FFT_WIDTH,
    parameter int M       = FFT_M,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH-1:0]   s_data,
    output logic               fft_reset,
    output logic               fft_start,
    output logic               fft_load,
    output logic [M-1:0]       fft_rd_adr,
    output logic [2*WIDTH-1:0] fft_rd,
    input  logic               fft_done,
    input  logic [2*WIDTH-1:0] fft_wd,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [2*WIDTH-1:0] m_data,
    output logic [M-1:0]       m_index,
    output logic               m_last,
    output logic               busy,
    output logic               error
);

    localparam int N  = 2**M;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    seq_state_t         state;
    logic [M-1:0]       ld_cnt;
    logic [M-1:0]       cap_cnt;
    logic [M-1:0]       rd_ptr;
    logic [TW-1:0]      timer;
    logic [LW-1:0]      cap_dly;
    logic               hs_in;
    logic               hs_out;
    logic               fetch;
    logic               wr_en;
    logic [2*WIDTH-1:0] rd_data;

    assign s_ready    = (state == LOAD);
    assign fft_reset  = (state == CLEAR);
    assign fft_start  = (state == START);
    assign busy       = (state != IDLE);

    assign hs_in      = s_valid & s_ready;
    assign fft_load   = hs_in;
    assign fft_rd_adr = ld_cnt;
    assign fft_rd     = hs_in ? pack_cplx(s_data, '0) : '0;

    assign wr_en      = (state == CAPTURE) && (cap_dly == '0);
    assign hs_out     = m_valid & m_ready;
    // Refill the output slot when it is empty or is being consumed, except after the last bin.
    assign fetch      = (state == DRAIN) && (!m_valid || (m_ready && !m_last));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ld_cnt  <= '0;
            cap_cnt <= '0;
            rd_ptr  <= '0;
            timer   <= '0;
            cap_dly <= '0;
            error   <= 1'b0;
            m_valid <= 1'b0;
            m_index <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= CLEAR;
                    end else begin
                        error <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= LOAD;
                end
                LOAD: begin
                    if (hs_in) begin
                        ld_cnt <= ld_cnt + M'(1);
                        if (ld_cnt == M'(N-1)) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fft_done) begin
                        cap_cnt <= '0;
                        cap_dly <= LW'(RD_LAT-1);
                        state   <= CAPTURE;
                    end else if (timer == TW'(TIMEOUT-1)) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                CAPTURE: begin
                    // Bin k appears RD_LAT+k cycles after the first done cycle; no stalls here.
                    if (cap_dly != '0) begin
                        cap_dly <= cap_dly - LW'(1);
                    end else begin
                        cap_cnt <= cap_cnt + M'(1);
                        if (cap_cnt == M'(N-1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fetch) begin
                        m_valid <= 1'b1;
                        m_index <= rd_ptr;
                        m_last  <= (rd_ptr == M'(N-1));
                        rd_ptr  <= rd_ptr + M'(1);
                    end else if (hs_out) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        m_index <= '0;
                        state   <= run ? CLEAR : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    fft_seq_buf #(
        .DW(2*WIDTH),
        .AW(M)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_adr  (cap_cnt),
        .wr_data (fft_wd),
        .rd_en   (fetch),
        .rd_adr  (rd_ptr),
        .rd_data (rd_data)
    );

`ifdef FFT_SEQ_MAG_EN
    assign m_data = pack_cplx('0, mag_sat(rd_data));
`else
    assign m_data = rd_data;
`endif

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - directed bench for fft_sequencer with a behavioural FFT core stub
module tb_fft_sequencer;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        fft_reset;
    logic        fft_start;
    logic        fft_load;
    logic [4:0]  fft_rd_adr;
    logic [31:0] fft_rd;
    logic        fft_done;
    logic [31:0] fft_wd;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [4:0]  m_index;
    logic        m_last;
    logic        busy;
    logic        error;

    int tests = 0;
    int fails = 0;
    int stub_mode = 0;
    int dcnt;
    int oidx;
    logic armed;

    always #5 clk = ~clk;

    fft_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .fft_reset  (fft_reset),
        .fft_start  (fft_start),
        .fft_load   (fft_load),
        .fft_rd_adr (fft_rd_adr),
        .fft_rd     (fft_rd),
        .fft_done   (fft_done),
        .fft_wd     (fft_wd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .busy       (busy),
        .error      (error)
    );

    // Mode 0: {k, ~k}; 1: {-3, 4}; 2: {0x7FFF, 0x7FFF}; 3: done never rises.
    function automatic logic [31:0] stub_data(input int mode, input int k);
        logic [15:0] kk;
        kk = 16'(k);
        case (mode)
            1:       return 32'hFFFD_0004;
            2:       return 32'h7FFF_7FFF;
            default: return {kk, ~kk};
        endcase
    endfunction

    function automatic logic [31:0] exp_data(input int mode, input int k);
`ifdef FFT_SEQ_MAG_EN
        case (mode)
            1:       return 32'h0000_0007;
            2:       return 32'h0000_7FFF;
            default: return 32'(2*k + 1);
        endcase
`else
        return stub_data(mode, k);
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            fft_done <= 1'b0;
            armed    <= 1'b0;
            dcnt     <= 0;
            oidx     <= 0;
            fft_wd   <= '0;
        end else begin
            if (fft_reset) begin
                fft_done <= 1'b0;
                armed    <= 1'b0;
            end else if (fft_start) begin
                armed <= (stub_mode != 3);
                dcnt  <= 0;
            end else if (armed && !fft_done) begin
                dcnt <= dcnt + 1;
                if (dcnt == 79) fft_done <= 1'b1;
            end
            oidx   <= fft_done ? oidx + 1 : 0;
            fft_wd <= fft_done ? stub_data(stub_mode, oidx) : '0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_frame(input bit gaps);
        int i;
        int guard;
        guard = 0;
        while (!fft_reset && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("clear_pulse", {63'd0, fft_reset}, 64'd1);
        i = 0;
        guard = 0;
        while (i < N && guard < 300) begin
            @(negedge clk);
            guard++;
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = 16'(i);
            #1;
            if (s_valid) begin
                chk("load", {s_ready, fft_load, fft_start, fft_reset, fft_rd_adr, fft_rd},
                    {4'b1100, 5'(i), 16'(i), 16'h0000});
                i++;
            end else begin
                chk("load_gap", {s_ready, fft_load, fft_start, fft_reset, fft_rd},
                    {4'b1000, 32'h0});
            end
        end
        chk("load_count", i, N);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'h5A5A;
        #1;
        chk("start", {fft_start, fft_reset, fft_load, s_ready, busy}, 5'b10001);
        @(negedge clk); #1;
        chk("wait_quiet", {fft_start, fft_load, s_ready, busy}, 4'b0001);
        s_valid = 1'b0;
    endtask

    task automatic drain_frame(input int mode, input bit rand_ready, input bit expect_clear);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < N && guard < 600) begin
            @(negedge clk);
            guard++;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_valid) begin
                chk("bin", {m_data, m_index, m_last}, {exp_data(mode, k), 5'(k), (k == N-1)});
                if (m_ready) k++;
            end
        end
        chk("drain_count", k, N);
        @(negedge clk); #1;
        m_ready = 1'b0;
        chk("after_drain", {fft_reset, m_valid, busy}, expect_clear ? 3'b101 : 3'b000);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctl", {busy, s_ready, fft_reset, fft_start, fft_load, fft_rd_adr, error}, 0);
        chk("reset_data", {fft_rd, m_data}, 0);
        chk("reset_out", {m_valid, m_index, m_last}, 0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("idle_hold", {busy, fft_reset}, 2'b00);

        run = 1'b1;
        stub_mode = 0;
        load_frame(1'b0);
        drain_frame(0, 1'b0, 1'b1);

        load_frame(1'b1);
        drain_frame(0, 1'b1, 1'b1);

        stub_mode = 1;
        load_frame(1'b0);
        drain_frame(1, 1'b0, 1'b1);

        stub_mode = 2;
        load_frame(1'b1);
        run = 1'b0;
        drain_frame(2, 1'b1, 1'b0);
        chk("no_error", {63'd0, error}, 64'd0);

        stub_mode = 3;
        run = 1'b1;
        load_frame(1'b0);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!error && n < 400);
        chk("timeout_len", n, 256);
        chk("timeout_idle", {error, busy}, 2'b10);
        run = 1'b0;
        @(negedge clk); #1;
        chk("error_clear", {error, busy}, 2'b00);

        stub_mode = 0;
        run = 1'b1;
        load_frame(1'b0);
        n = 0;
        while (!fft_done && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", {63'd0, fft_done}, 64'd1);
        repeat (5) @(negedge clk);
        #1;
        chk("in_capture", {busy, m_valid, s_ready}, 3'b100);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_ctl", {busy, s_ready, fft_reset, fft_start, fft_load, fft_rd_adr, error}, 0);
        chk("abort_out", {m_valid, m_index, m_last, m_data}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("restart_clear", {fft_reset, fft_load, fft_start, busy}, 4'b1001);
        load_frame(1'b0);
        run = 1'b0;
        drain_frame(0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
